// File: rtl/dlatch_bank.sv
// Bank of DEPTH gated storage words with selectable latch/edge/toggle write modes,
// registered write-through readback, update pulse and wrapping update counter.

module dlatch_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] word
);
  always_ff @(posedge clk) begin
    if (!rst_n)  word <= '0;
    else if (we) word <= wdata;
  end
endmodule

module dlatch_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             gate,
  input  logic [AW-1:0]    sel,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    rd_sel,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             upd,
  output logic [7:0]       upd_cnt
);
  logic                        gate_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            we;
  logic                        rise, fall, hit, sel_ok, wr;
  logic [WIDTH-1:0]            cur_w, rd_w, wdata;

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

  // Decoded lookups: selects past DEPTH match nothing, so they read 0 and never write.
  always_comb begin
    sel_ok = 1'b0;
    cur_w  = '0;
    rd_w   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == AW'(i)) begin
        sel_ok = 1'b1;
        cur_w  = mem[i];
      end
      if (rd_sel == AW'(i)) rd_w = mem[i];
    end
  end

  always_comb begin
    case (mode)
      2'b00:   hit = gate;
      2'b01:   hit = rise;
      2'b10:   hit = fall;
      default: hit = rise;
    endcase
  end

  assign wr    = ena & sel_ok & hit;
  assign wdata = (mode == 2'b11) ? (cur_w ^ d) : d;

  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++) we[i] = wr && (sel == AW'(i));
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    dlatch_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[w]),
      .wdata (wdata),
      .word  (mem[w])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_d  <= 1'b0;
      q       <= '0;
      upd     <= 1'b0;
      upd_cnt <= '0;
    end else begin
      gate_d  <= gate;
      q       <= (wr && rd_sel == sel) ? wdata : rd_w;
      upd     <= wr;
      upd_cnt <= clr ? {7'b0, wr} : upd_cnt + {7'b0, wr};
    end
  end
endmodule

// File: tb/tb_dlatch_bank.sv
// Bench for dlatch_bank: a DEPTH=4 and a DEPTH=3 instance share stimulus and are
// checked against a spec-level model, a vector table and hand-built sequences.

module tb_dlatch_bank;
  logic       clk = 1'b0;
  logic       rst_n, ena, gate, clr;
  logic [1:0] mode, sel, rd_sel;
  logic [7:0] d;
  logic [7:0] q4, q3, cnt4, cnt3;
  logic       upd4, upd3;

  int errors = 0;
  int checks = 0;
  bit mvalid = 0;

  always #5 clk = ~clk;

  dlatch_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .gate(gate), .sel(sel),
    .d(d), .rd_sel(rd_sel), .clr(clr), .q(q4), .upd(upd4), .upd_cnt(cnt4));

  dlatch_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .gate(gate), .sel(sel),
    .d(d), .rd_sel(rd_sel), .clr(clr), .q(q3), .upd(upd3), .upd_cnt(cnt3));

  typedef struct packed {
    logic [3:0][7:0] mem;
    logic            gd;
    logic [7:0]      q;
    logic            upd;
    logic [7:0]      cnt;
  } mstate_t;

  mstate_t m4, m3;

  // Reference: applies the documented write/readback/count rules to the inputs
  // present at a clock edge.
  function automatic mstate_t mstep(mstate_t s, int depth);
    mstate_t    n;
    logic       hit, wr;
    logic [7:0] nv;
    n = s;
    if (!rst_n) return '0;
    case (mode)
      2'd0:    hit = gate;
      2'd1:    hit = gate && !s.gd;
      2'd2:    hit = !gate && s.gd;
      default: hit = gate && !s.gd;
    endcase
    wr = ena && (int'(sel) < depth) && hit;
    nv = (mode == 2'd3) ? (s.mem[sel] ^ d) : d;
    if (wr && rd_sel == sel)       n.q = nv;
    else if (int'(rd_sel) < depth) n.q = s.mem[rd_sel];
    else                           n.q = 8'h00;
    if (wr) n.mem[sel] = nv;
    n.upd = wr;
    n.cnt = clr ? 8'(wr) : 8'((int'(s.cnt) + int'(wr)) % 256);
    n.gd  = gate;
    return n;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) mvalid = 1;
    m4 = mstep(m4, 4);
    m3 = mstep(m3, 3);
    #1;
    if (mvalid) begin
      check("model q4",   q4,         m4.q);
      check("model upd4", 8'(upd4),   8'(m4.upd));
      check("model cnt4", cnt4,       m4.cnt);
      check("model q3",   q3,         m3.q);
      check("model upd3", 8'(upd3),   8'(m3.upd));
      check("model cnt3", cnt3,       m3.cnt);
    end
  endtask

  typedef struct {
    logic       ena;
    logic [1:0] mode;
    logic       gate;
    logic [1:0] sel;
    logic [7:0] d;
    logic [1:0] rd;
    logic       clr;
    logic [7:0] eq;
    logic       eu;
    logic [7:0] ec;
  } vec_t;

  vec_t vt[$];

  task automatic add(logic e, logic [1:0] m, logic g, logic [1:0] s, logic [7:0] dd,
                     logic [1:0] r, logic c, logic [7:0] eq, logic eu, logic [7:0] ec);
    vec_t v;
    v = '{e, m, g, s, dd, r, c, eq, eu, ec};
    vt.push_back(v);
  endtask

  initial begin
    m4 = '0; m3 = '0;
    rst_n = 1; ena = 0; mode = 0; gate = 0; sel = 0; d = 0; rd_sel = 0; clr = 0;

    // Reset: junk first, then two reset cycles, then read every word with ena=0
    for (int i = 0; i < 5; i++) begin
      ena = 1'($urandom); mode = 2'($urandom); gate = 1'($urandom);
      sel = 2'($urandom); d = 8'($urandom); rd_sel = 2'($urandom); clr = 1'($urandom);
      step();
    end
    rst_n = 0; gate = 0; ena = 0; clr = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      step();
      check($sformatf("reset q word%0d", i), q4, 8'h00);
      check("reset upd", 8'(upd4), 8'h00);
      check("reset cnt", cnt4, 8'h00);
    end

    //   ena mode gate sel d      rd clr   q      upd cnt
    add(1, 0, 1, 2, 8'h11, 2, 0, 8'h11, 1, 8'd1);
    add(1, 0, 1, 2, 8'h22, 2, 0, 8'h22, 1, 8'd2);
    add(1, 0, 1, 2, 8'h33, 2, 0, 8'h33, 1, 8'd3);
    add(1, 0, 0, 2, 8'h44, 2, 0, 8'h33, 0, 8'd3);
    add(1, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 8'd3);
    add(1, 1, 1, 1, 8'hA5, 1, 0, 8'hA5, 1, 8'd4);
    add(1, 1, 1, 1, 8'h5A, 1, 0, 8'hA5, 0, 8'd4);
    add(1, 2, 0, 0, 8'h3C, 0, 0, 8'h3C, 1, 8'd5);
    add(1, 0, 1, 3, 8'h0F, 3, 0, 8'h0F, 1, 8'd6);
    add(1, 3, 0, 3, 8'hFF, 3, 0, 8'h0F, 0, 8'd6);
    add(1, 3, 1, 3, 8'hFF, 3, 0, 8'hF0, 1, 8'd7);
    add(1, 3, 0, 3, 8'hFF, 3, 0, 8'hF0, 0, 8'd7);
    add(1, 3, 1, 3, 8'hFF, 3, 0, 8'h0F, 1, 8'd8);
    add(1, 3, 0, 3, 8'hFF, 3, 0, 8'h0F, 0, 8'd8);
    add(1, 3, 1, 3, 8'hFF, 3, 0, 8'hF0, 1, 8'd9);
    add(0, 1, 0, 2, 8'h99, 3, 0, 8'hF0, 0, 8'd9);
    add(0, 1, 1, 2, 8'h99, 2, 0, 8'h33, 0, 8'd9);
    add(1, 1, 1, 2, 8'h99, 2, 0, 8'h33, 0, 8'd9);
    add(1, 0, 1, 2, 8'h77, 2, 0, 8'h77, 1, 8'd10);
    add(1, 1, 1, 2, 8'h88, 2, 0, 8'h77, 0, 8'd10);
    add(1, 1, 0, 2, 8'h88, 2, 0, 8'h77, 0, 8'd10);
    add(1, 1, 1, 2, 8'h88, 2, 0, 8'h88, 1, 8'd11);
    add(0, 0, 0, 0, 8'h00, 1, 0, 8'hA5, 0, 8'd11);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 0, 8'd0);

    foreach (vt[i]) begin
      ena = vt[i].ena; mode = vt[i].mode; gate = vt[i].gate; sel = vt[i].sel;
      d = vt[i].d; rd_sel = vt[i].rd; clr = vt[i].clr;
      step();
      check($sformatf("vec%0d q", i),   q4,       vt[i].eq);
      check($sformatf("vec%0d upd", i), 8'(upd4), 8'(vt[i].eu));
      check($sformatf("vec%0d cnt", i), cnt4,     vt[i].ec);
    end

    // DEPTH=3: select 3 is out of range, so no write, no pulse, reads as 0
    ena = 0; clr = 1; step();
    clr = 0; ena = 1; mode = 0; gate = 1; sel = 3; rd_sel = 3; d = 8'h55;
    step();
    check("d3 oob q",   q3,       8'h00);
    check("d3 oob upd", 8'(upd3), 8'h00);
    check("d3 oob cnt", cnt3,     8'h00);
    check("d4 sel3 q",  q4,       8'h55);
    check("d4 sel3 upd", 8'(upd4), 8'h01);

    // Counter wrap, then clr coinciding with a write
    ena = 0; clr = 1; step();
    clr = 0; ena = 1; mode = 0; gate = 1; sel = 0; rd_sel = 0;
    for (int i = 0; i < 255; i++) begin
      d = 8'(i);
      step();
    end
    check("cnt 255", cnt4, 8'd255);
    step();
    check("cnt wrap", cnt4, 8'd0);
    clr = 1; step();
    check("cnt clr+wr", cnt4, 8'd1);
    check("upd clr+wr", 8'(upd4), 8'h01);
    clr = 0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(63) != 0);
      ena    = ($urandom_range(3) != 0);
      mode   = 2'($urandom);
      gate   = 1'($urandom);
      sel    = 2'($urandom);
      rd_sel = 2'($urandom);
      d      = 8'($urandom);
      clr    = ($urandom_range(15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dlatch_bank.md
Name: dlatch_bank

Overview:
- Parametrised successor to the single D-latch tile: a bank of DEPTH gated storage words, each WIDTH bits wide.
- Mode input selects per-cycle behaviour: transparent latch, rising-edge capture, falling-edge capture, or toggle-on-edge.
- Registered write-through readback, update pulse and update counter for on-chip observation.
- Instantiated inside the tile wrapper; fully synchronous to the tile clock.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 4, number of words (need not be a power of two).
- AW, $clog2(DEPTH) (min 1), select width; derived, not overridden.

Ports:
- clk  in  1  tile clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  write enable for the whole bank; 0 blocks all writes.
- mode  in  2  00 transparent, 01 rise capture, 10 fall capture, 11 toggle.
- gate  in  1  latch gate, sampled on clk.
- sel  in  AW  write word select.
- d  in  WIDTH  write data.
- rd_sel  in  AW  read word select.
- clr  in  1  clears upd_cnt.
- q  out  WIDTH  registered read data.
- upd  out  1  one-cycle pulse, high the cycle after any word write.
- upd_cnt  out  8  count of word writes, wraps 255->0.

Behaviour:
- Reset (rst_n=0 at a clk rising edge): all words = 0, q = 0, gate_d = 0, upd = 0, upd_cnt = 0. Reset takes priority over every other input. Mid-operation reset discards any edge in progress.
- gate_d <= gate every cycle, independent of ena and mode.
- rise = gate & ~gate_d; fall = ~gate & gate_d.
- Write condition wr (requires ena=1 and sel < DEPTH):
  - mode 00: gate=1 -> mem[sel] <= d, every cycle gate stays high.
  - mode 01: rise -> mem[sel] <= d.
  - mode 10: fall -> mem[sel] <= d.
  - mode 11: rise -> mem[sel] <= mem[sel] ^ d.
- Edges that occur while ena=0 are lost. They are not deferred.
- Mode changes take effect in the same cycle. gate_d is not reset on a mode change, so switching to 01 with gate already high produces no write.
- sel >= DEPTH: the write is ignored, with no upd and no count.
- Readback: q <= (wr && rd_sel==sel) ? new value : mem[rd_sel] (write-through).
  - Latency from the sampling edge to q is one cycle.
  - rd_sel >= DEPTH gives q <= 0.
- upd <= wr.
- Counter:
  - upd_cnt <= clr ? (wr ? 1 : 0) : upd_cnt + wr, wrapping at 8 bits.
  - clr and wr together give a count of 1.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive random inputs, then rst_n=0 for 2 cycles, then rst_n=1 with ena=0. Required: q=0, upd=0, upd_cnt=0; reading all 4 words gives 0.
- Transparent mode: mode=00, ena=1, sel=2, rd_sel=2, gate=1, d sequence 0x11, 0x22, 0x33 on successive cycles, then gate=0 with d=0x44. Required: q = 0x11, 0x22, 0x33, 0x33 (each one cycle late); upd_cnt=3.
- Edge modes:
  - mode=01, gate 0->1 with d=0xA5 on sel=1, then d=0x5A with gate held high. Required: word1=0xA5 and exactly one upd pulse.
  - mode=10, gate 1->0 with d=0x3C on sel=0. Required: word0=0x3C.
- Toggle mode: mode=11, sel=3, word3=0x0F, three rising edges with d=0xFF. Required: q = 0xF0, then 0x0F, then 0xF0.
- Boundaries:
  - ena=0 during a rising edge. Required: no write and no upd.
  - Switch mode 00 to 01 while gate is high. Required: no write until gate falls and rises again.
  - DEPTH=3 with sel=3. Required: write ignored; rd_sel=3 gives q=0.
- Counter: 255 writes, then 1 more. Required: upd_cnt=255, then 0. Then clr together with a write. Required: upd_cnt=1.
